// File: rtl/display_pkg.sv
// Shared scan-driver types and constants.
// Digit count, index width, anode-off pattern, FSM states.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/display_scan_driver_if.sv
// Scan driver bus: enables in, digit select/anodes/ticks out.
// master = controller side, slave = display_scan_driver.
interface display_scan_driver_if;
  import display_pkg::*;

  logic                  en;
  logic [NUM_DIGITS-1:0] digit_en;
  logic [IDX_W-1:0]      refreshcounter;
  logic [NUM_DIGITS-1:0] anode;
  logic                  slot_tick;
  logic                  frame_tick;

  modport master (
    output en, digit_en,
    input  refreshcounter, anode,
    input  slot_tick, frame_tick
  );

  modport slave (
    input  en, digit_en,
    output refreshcounter, anode,
    output slot_tick, frame_tick
  );

endinterface

// File: rtl/display_scan_driver_scan_prescaler.sv
// Slot counter: counts 0..PRESCALE-1 while run, else held at 0.
// Ports: clk, rst_n, run in; tc, blank_end flags out.
// DISPLAY_SCAN_DEADTIME_EN: blank_end at BLANK_CYCLES-1, else at 0.
module scan_prescaler #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tc,
  output logic blank_end
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

`ifdef DISPLAY_SCAN_DEADTIME_EN
  localparam bit DEADTIME = 1'b1;
`else
  localparam bit DEADTIME = 1'b0;
`endif

  // Without dead time the blank phase is only the index-change cycle.
  localparam int BLANK_LAST = DEADTIME ? BLANK_CYCLES - 1 : 0;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc        = cnt_q == CW'(PRESCALE - 1);
  assign blank_end = cnt_q == CW'(BLANK_LAST);

  always_comb begin
    cnt_d = '0;
    if (run && !tc)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed 4-digit display scan driver with blanking.
// Ports: clk, rst_n, bus (slave): en, digit_en -> refreshcounter,
// anode (active low), slot_tick, frame_tick; all outputs registered.
// Macro DISPLAY_SCAN_DEADTIME_EN: BLANK lasts BLANK_CYCLES cycles.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input logic clk,
  input logic rst_n,
  display_scan_driver_if.slave bus
);

  scan_state_e state_q, state_d;

  logic [IDX_W-1:0]      rc_q, rc_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic                  slot_q, slot_d;
  logic                  frame_q, frame_d;

  logic run, tc, blank_end;

  // Counter restarts from 0 on the first BLANK cycle after IDLE.
  assign run = bus.en && (state_q != IDLE);

  scan_prescaler #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .tc        (tc),
    .blank_end (blank_end)
  );

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    slot_d  = 1'b0;
    frame_d = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = BLANK;
        BLANK: if (blank_end) state_d = SHOW;
        SHOW: begin
          if (tc) begin
            state_d = BLANK;
            rc_d    = rc_q + IDX_W'(1);
            slot_d  = 1'b1;
            frame_d = rc_q == IDX_W'(NUM_DIGITS - 1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Anodes follow the next state so the index only moves
    // while every anode is off.
    anode_d = ANODE_OFF;
    if (state_d == SHOW && bus.digit_en[rc_d])
      anode_d[rc_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rc_q    <= '0;
      anode_q <= ANODE_OFF;
      slot_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      anode_q <= anode_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  assign bus.refreshcounter = rc_q;
  assign bus.anode          = anode_q;
  assign bus.slot_tick      = slot_q;
  assign bus.frame_tick     = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver (PRESCALE=8, BLANK_CYCLES=2).
// Slot-timeline scoreboard, duty-count table, en-drop and async reset cases.
module tb_display_scan_driver;

  localparam int P = 8;
  localparam int B = 2;
`ifdef DISPLAY_SCAN_DEADTIME_EN
  localparam int BLEN = B;
`else
  localparam int BLEN = 1;
`endif
  localparam int SLEN = P - BLEN;

  typedef struct packed {
    logic [3:0] anode;
    logic [1:0] rc;
    logic       st;
    logic       ft;
  } obs_t;

  typedef struct {
    logic [3:0] de;
    int         low[4];
    int         st;
    int         ft;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail = 0;
  obs_t q[$];

  display_scan_driver_if bus ();

  display_scan_driver #(
    .PRESCALE     (P),
    .BLANK_CYCLES (B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.anode = bus.anode;
    o.rc    = bus.refreshcounter;
    o.st    = bus.slot_tick;
    o.ft    = bus.frame_tick;
    return o;
  endfunction

  // Expected outputs k cycles after leaving IDLE, from the slot timeline.
  function automatic obs_t model(input int k, input logic [3:0] de,
                                 input logic [1:0] base);
    obs_t o;
    int slot, pos;
    slot    = k / P;
    pos     = k % P;
    o.rc    = 2'(int'(base) + slot);
    o.anode = 4'hF;
    if (pos >= BLEN && de[o.rc]) o.anode[o.rc] = 1'b0;
    o.st    = (k > 0) && (pos == 0);
    o.ft    = o.st && (o.rc == 2'd0);
    return o;
  endfunction

  task automatic tick_check(input string nm);
    obs_t e;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check(nm, 32'(sample()), 32'(e));
    end
  endtask

  task automatic run_scan(input string nm, input int k0, input int n,
                          input logic [1:0] base, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && (i % 5 == 0)) bus.digit_en = 4'($urandom);
      q.push_back(model(k0 + i, bus.digit_en, base));
      tick_check($sformatf("%s k%0d", nm, k0 + i));
    end
  endtask

  task automatic do_reset(input logic [3:0] de);
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.digit_en = de;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.en = 1'b1;
  endtask

  vec_t vt[5];

  initial begin
    vt[0] = '{de: 4'hF,    low: '{SLEN, SLEN, SLEN, SLEN}, st: 4, ft: 1};
    vt[1] = '{de: 4'b0101, low: '{SLEN, 0, SLEN, 0},       st: 4, ft: 1};
    vt[2] = '{de: 4'b0000, low: '{0, 0, 0, 0},             st: 4, ft: 1};
    vt[3] = '{de: 4'b1000, low: '{0, 0, 0, SLEN},          st: 4, ft: 1};
    vt[4] = '{de: 4'b1010, low: '{0, SLEN, 0, SLEN},       st: 4, ft: 1};

    // Reset state and idle with en low.
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.digit_en = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    check("reset", 32'(sample()), 32'({4'hF, 2'd0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_en0", 32'(sample()), 32'({4'hF, 2'd0, 1'b0, 1'b0}));

    // Continuous scan, then random digit_en changes.
    bus.en = 1'b1;
    run_scan("scan", 0, 40, 2'd0, 1'b0);
    run_scan("scan_rnd", 40, 60, 2'd0, 1'b1);

    // Duty and tick counts over one full frame (k=0..32).
    foreach (vt[v]) begin
      int low[4];
      int st, ft, ft_bad;
      low = '{0, 0, 0, 0};
      st = 0;
      ft = 0;
      ft_bad = 0;
      do_reset(vt[v].de);
      for (int k = 0; k <= 4 * P; k++) begin
        @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++)
          if (!bus.anode[d]) low[d]++;
        if (bus.slot_tick) st++;
        if (bus.frame_tick) begin
          ft++;
          if (!bus.slot_tick || bus.refreshcounter != 2'd0) ft_bad++;
        end
      end
      for (int d = 0; d < 4; d++)
        check($sformatf("duty v%0d d%0d", v, d), low[d], vt[v].low[d]);
      check($sformatf("slot_ticks v%0d", v), st, vt[v].st);
      check($sformatf("frame_ticks v%0d", v), ft, vt[v].ft);
      check($sformatf("frame_align v%0d", v), ft_bad, 0);
    end

    // Drop en during SHOW of digit 2, then resume.
    do_reset(4'hF);
    run_scan("pre_drop", 0, 2 * P + BLEN + 1, 2'd0, 1'b0);
    bus.en = 1'b0;
    q.push_back('{anode: 4'hF, rc: 2'd2, st: 1'b0, ft: 1'b0});
    tick_check("en_drop");
    q.push_back('{anode: 4'hF, rc: 2'd2, st: 1'b0, ft: 1'b0});
    tick_check("en_low_hold");
    bus.en = 1'b1;
    run_scan("resume", 0, P + 2, 2'd2, 1'b0);

    // Asynchronous reset in the middle of SHOW.
    do_reset(4'hF);
    run_scan("pre_rst", 0, P + BLEN + 2, 2'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'(sample()), 32'({4'hF, 2'd0, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_scan("post_rst", 0, P + 1, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
